// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver
//   Time-multiplexed N-digit 7-segment driver for common-anode displays.
//   A load strobe captures a packed nibble vector into a shadow register; the
//   shadow is copied to the display register only at the frame boundary so a
//   frame never mixes old and new digits. Each digit slot lasts DIV cycles,
//   the first BLANK_CYC of which keep every anode off to stop ghosting.
//
// Ports
//   clk, rst      system clock, asynchronous active-high reset
//   load          one-cycle strobe capturing value/dp_in
//   value         packed nibbles, [3:0] = digit 0 (rightmost)
//   dp_in         decimal point request per digit (1 = lit)
//   lz_en         leading-zero suppression enable, sampled live
//   seg           {a,b,c,d,e,f,g}, active-low
//   dp_n          decimal point, active-low
//   an_n          digit enables, active-low, one-cold
//   frame_start   one-cycle pulse on the first cycle of digit 0's slot
// ---------------------------------------------------------------------------
module seg7_scan_driver #(
  parameter int DIGITS    = 4,
  parameter int DIV       = 1000,
  parameter int BLANK_CYC = 1,
  parameter int HEX_MODE  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  lz_en,
  output logic [6:0]            seg,
  output logic                  dp_n,
  output logic [DIGITS-1:0]     an_n,
  output logic                  frame_start
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);

  // Scan state
  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  // Load path: shadow holds the latest request, disp is what is on the glass
  logic [4*DIGITS-1:0]   shadow_val_q, shadow_val_d;
  logic [DIGITS-1:0]     shadow_dp_q, shadow_dp_d;
  logic                  pending_q, pending_d;
  logic [4*DIGITS-1:0]   disp_val_q, disp_val_d;
  logic [DIGITS-1:0]     disp_dp_q, disp_dp_d;
  // Registered outputs
  logic [6:0]            seg_q, seg_d;
  logic                  dp_n_q, dp_n_d;
  logic [DIGITS-1:0]     an_n_q, an_n_d;
  logic                  frame_start_q, frame_start_d;

  // Combinational helpers
  logic                  slot_end;
  logic                  frame_end;
  logic                  zero_run;
  logic [DIGITS-1:0]     lead_blank;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_blank;

  function automatic logic [6:0] glyph(input logic [3:0] code);
    logic [6:0] g;
    g = 7'b1111111;
    case (code)
      4'h0: g = 7'b0000001;
      4'h1: g = 7'b1001111;
      4'h2: g = 7'b0010010;
      4'h3: g = 7'b0000110;
      4'h4: g = 7'b1001100;
      4'h5: g = 7'b0100100;
      4'h6: g = 7'b0100000;
      4'h7: g = 7'b0001111;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0000100;
      default: begin
        if (HEX_MODE != 0) begin
          case (code)
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b1100000;
            4'hC:    g = 7'b0110001;
            4'hD:    g = 7'b1000010;
            4'hE:    g = 7'b0110000;
            default: g = 7'b0111000;
          endcase
        end
      end
    endcase
    return g;
  endfunction

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    slot_end     = (presc_q == PRESC_MAX);
    frame_end    = slot_end && (idx_q == IDX_MAX);
    presc_d      = slot_end ? '0 : presc_q + PW'(1);
    idx_d        = idx_q;
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    pending_d    = pending_q;
    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;

    if (slot_end) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
    end

    if (load) begin
      shadow_val_d = value;
      shadow_dp_d  = dp_in;
      pending_d    = 1'b1;
    end

    // Display swaps only on the last cycle of a frame; a load on that very
    // edge bypasses the shadow so it is still seen in the next frame.
    if (frame_end) begin
      if (pending_q || load) begin
        disp_val_d = load ? value : shadow_val_q;
        disp_dp_d  = load ? dp_in : shadow_dp_q;
      end
      pending_d = 1'b0;
    end

    // Leading-zero run from the top digit; digit 0 always stays visible.
    zero_run   = 1'b1;
    lead_blank = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run      = zero_run && (disp_val_q[4*i +: 4] == 4'd0) && !disp_dp_q[i];
      lead_blank[i] = zero_run && (i != 0);
    end

    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_nib   = disp_val_q[4*i +: 4];
        cur_dp    = disp_dp_q[i];
        cur_blank = lz_en && lead_blank[i];
      end
    end

    seg_d         = cur_blank ? 7'b1111111 : glyph(cur_nib);
    dp_n_d        = ~cur_dp;
    an_n_d        = (int'(presc_q) < BLANK_CYC) ? '1 : ~(DIGITS'(1) << idx_q);
    frame_start_d = (presc_q == '0) && (idx_q == '0);
  end

  // NOTE: the display and shadow registers are reset too, so a reset blanks the latched value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q       <= '0;
      idx_q         <= '0;
      shadow_val_q  <= '0;
      shadow_dp_q   <= '0;
      pending_q     <= 1'b0;
      disp_val_q    <= '0;
      disp_dp_q     <= '0;
      seg_q         <= 7'b1111111;
      dp_n_q        <= 1'b1;
      an_n_q        <= '1;
      frame_start_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      shadow_val_q  <= shadow_val_d;
      shadow_dp_q   <= shadow_dp_d;
      pending_q     <= pending_d;
      disp_val_q    <= disp_val_d;
      disp_dp_q     <= disp_dp_d;
      seg_q         <= seg_d;
      dp_n_q        <= dp_n_d;
      an_n_q        <= an_n_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign seg         = seg_q;
  assign dp_n        = dp_n_q;
  assign an_n        = an_n_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_driver
//   Drives two copies of the driver (HEX_MODE 0 and 1) with the same
//   directed stimulus. A frame-level model predicts every output each cycle;
//   directed frame checks pin the model against hand-computed glyphs.
// ---------------------------------------------------------------------------
module tb_seg7_scan_driver;

  localparam int DIGITS    = 4;
  localparam int DIV       = 4;
  localparam int BLANK_CYC = 1;
  localparam int FRAME     = DIGITS * DIV;

  localparam logic [6:0] G0 = 7'b0000001;
  localparam logic [6:0] G1 = 7'b1001111;
  localparam logic [6:0] G2 = 7'b0010010;
  localparam logic [6:0] G3 = 7'b0000110;
  localparam logic [6:0] G4 = 7'b1001100;
  localparam logic [6:0] G5 = 7'b0100100;
  localparam logic [6:0] G7 = 7'b0001111;
  localparam logic [6:0] G9 = 7'b0000100;
  localparam logic [6:0] GX = 7'b1111111;

  localparam logic [6:0] GLYPH [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        lz_en;
  logic [6:0]  seg, seg_h;
  logic        dp_n, dp_n_h;
  logic [3:0]  an_n, an_n_h;
  logic        frame_start, frame_start_h;
  logic        cmp_en;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.DIGITS(DIGITS), .DIV(DIV), .BLANK_CYC(BLANK_CYC), .HEX_MODE(0)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in), .lz_en(lz_en),
    .seg(seg), .dp_n(dp_n), .an_n(an_n), .frame_start(frame_start)
  );

  seg7_scan_driver #(.DIGITS(DIGITS), .DIV(DIV), .BLANK_CYC(BLANK_CYC), .HEX_MODE(1)) dut_hex (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in), .lz_en(lz_en),
    .seg(seg_h), .dp_n(dp_n_h), .an_n(an_n_h), .frame_start(frame_start_h)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Time is counted in cycles since reset release: slot = n / DIV, position
  // within slot = n % DIV. Loads made since the last frame boundary are
  // shown from the next boundary on, the latest one winning.
  int         m_n;
  logic [15:0] m_disp, m_req;
  logic [3:0]  m_disp_dp, m_req_dp;
  logic        m_req_valid;
  logic [6:0]  exp_seg, exp_seg_h;
  logic        exp_dp_n, exp_fs;
  logic [3:0]  exp_an_n;

  function automatic logic [6:0] model_glyph(input logic [3:0] code, input bit hex);
    if (code > 4'd9 && !hex) return GX;
    return GLYPH[code];
  endfunction

  // Blank when the digit sits above the highest digit carrying content.
  function automatic bit model_blank(input int idx, input logic [15:0] v, input logic [3:0] d);
    int top = 0;
    for (int k = 0; k < DIGITS; k++)
      if (v[4*k +: 4] != 4'd0 || d[k]) top = k;
    return idx > top;
  endfunction

  function automatic logic [3:0] model_an(input int n);
    logic [3:0] a = 4'hF;
    if ((n % DIV) >= BLANK_CYC) a[(n / DIV) % DIGITS] = 1'b0;
    return a;
  endfunction

  function automatic int model_idx(input int n);
    return (n / DIV) % DIGITS;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_n         <= 0;
      m_disp      <= '0;
      m_disp_dp   <= '0;
      m_req       <= '0;
      m_req_dp    <= '0;
      m_req_valid <= 1'b0;
      exp_seg     <= GX;
      exp_seg_h   <= GX;
      exp_dp_n    <= 1'b1;
      exp_an_n    <= 4'hF;
      exp_fs      <= 1'b0;
    end else begin
      exp_an_n  <= model_an(m_n);
      exp_fs    <= (m_n % FRAME) == 0;
      exp_dp_n  <= ~m_disp_dp[model_idx(m_n)];
      exp_seg   <= (lz_en && model_blank(model_idx(m_n), m_disp, m_disp_dp)) ? GX
                   : model_glyph(m_disp[4*model_idx(m_n) +: 4], 1'b0);
      exp_seg_h <= (lz_en && model_blank(model_idx(m_n), m_disp, m_disp_dp)) ? GX
                   : model_glyph(m_disp[4*model_idx(m_n) +: 4], 1'b1);
      if (((m_n + 1) % FRAME) == 0) begin
        if (load) begin
          m_disp    <= value;
          m_disp_dp <= dp_in;
        end else if (m_req_valid) begin
          m_disp    <= m_req;
          m_disp_dp <= m_req_dp;
        end
        m_req_valid <= 1'b0;
      end else if (load) begin
        m_req_valid <= 1'b1;
      end
      if (load) begin
        m_req    <= value;
        m_req_dp <= dp_in;
      end
      m_n <= m_n + 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp_seg",   seg,           exp_seg);
      check("cmp_seg_h", seg_h,         exp_seg_h);
      check("cmp_dp_n",  dp_n,          exp_dp_n);
      check("cmp_dp_nh", dp_n_h,        exp_dp_n);
      check("cmp_an_n",  an_n,          exp_an_n);
      check("cmp_an_nh", an_n_h,        exp_an_n);
      check("cmp_fs",    frame_start,   exp_fs);
      check("cmp_fs_h",  frame_start_h, exp_fs);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_frame();
    int n = 0;
    while (frame_start !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("frame_seen", frame_start, 1'b1);
  endtask

  // Walks one full frame from its frame_start cycle; s/sh are {d3,d2,d1,d0}.
  task automatic check_frame(input string name, input logic [3:0][6:0] s,
                             input logic [3:0][6:0] sh, input logic [3:0] dpn);
    logic [3:0] exp_an;
    wait_frame();
    for (int k = 0; k < DIGITS; k++) begin
      check({name, "_blank_an"}, an_n, 4'hF);
      check({name, "_seg"}, seg, s[k]);
      check({name, "_seg_hex"}, seg_h, sh[k]);
      check({name, "_dp_n"}, dp_n, dpn[k]);
      @(negedge clk);
      exp_an    = 4'hF;
      exp_an[k] = 1'b0;
      check({name, "_an"}, an_n, exp_an);
      check({name, "_seg_lit"}, seg, s[k]);
      repeat (DIV - 1) @(negedge clk);
    end
    check({name, "_fs_period"}, frame_start, 1'b1);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp_in = d;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    cmp_en = 1'b0;
    rst    = 1'b1;
    load   = 1'b0;
    value  = '0;
    dp_in  = '0;
    lz_en  = 1'b0;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;

    check("rst_an",  an_n, 4'hF);
    check("rst_seg", seg, GX);
    check("rst_dp",  dp_n, 1'b1);
    check("rst_fs",  frame_start, 1'b0);

    rst = 1'b0;
    @(negedge clk);
    check("rel_fs",  frame_start, 1'b1);
    check("rel_an",  an_n, 4'hF);
    check("rel_seg", seg, G0);

    check_frame("idle", {G0, G0, G0, G0}, {G0, G0, G0, G0}, 4'hF);

    // Load mid-frame: the frame in progress keeps showing zeros.
    repeat (5) @(negedge clk);
    do_load(16'h1234, 4'h0);
    check("mid_frame_old", seg, G0);
    check_frame("v1234", {G1, G2, G3, G4}, {G1, G2, G3, G4}, 4'hF);

    lz_en = 1'b1;
    do_load(16'h0070, 4'h0);
    check_frame("lz", {GX, GX, G7, G0}, {GX, GX, G7, G0}, 4'hF);

    do_load(16'h0070, 4'b0100);
    check_frame("lz_dp", {GX, G0, G7, G0}, {GX, G0, G7, G0}, 4'b1011);

    lz_en = 1'b0;
    do_load(16'hABCF, 4'h0);
    check_frame("hex", {GX, GX, GX, GX},
                {7'b0001000, 7'b1100000, 7'b0110001, 7'b0111000}, 4'hF);

    // Two loads in one frame: only the last one reaches the display.
    repeat (2) @(negedge clk);
    do_load(16'h1111, 4'h0);
    repeat (3) @(negedge clk);
    do_load(16'h9999, 4'h0);
    check_frame("last_wins", {G9, G9, G9, G9}, {G9, G9, G9, G9}, 4'hF);

    // Load held across the frame-wrap edge shows in the very next frame.
    repeat (FRAME - 2) @(negedge clk);
    check("pre_wrap_fs", frame_start, 1'b0);
    do_load(16'h5555, 4'h0);
    check_frame("wrap_load", {G5, G5, G5, G5}, {G5, G5, G5, G5}, 4'hF);

    // Reset in the middle of digit 2's slot.
    repeat (2 * DIV + 1) @(negedge clk);
    check("slot2_an", an_n, 4'b1011);
    #2 rst = 1'b1;
    #1;
    check("midrst_an",  an_n, 4'hF);
    check("midrst_seg", seg, GX);
    check("midrst_dp",  dp_n, 1'b1);
    check("midrst_fs",  frame_start, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_fs",  frame_start, 1'b1);
    check("post_rst_seg", seg, G0);
    check_frame("post_rst", {G0, G0, G0, G0}, {G0, G0, G0, G0}, 4'hF);

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Parametrised, time-multiplexed N-digit 7-segment display driver. It is the sequential successor to the team's single-digit BCD decoder.
- Latches a packed nibble vector and scans the digits one at a time with a programmable refresh divider.
- Supports optional hex glyphs, leading-zero suppression, per-digit decimal points and an inter-digit blanking gap for anti-ghosting.
- Sits between the datapath (counters, registers) and the board's common-anode display pins.

Parameters:
- DIGITS, 4, number of digits scanned; 1..8.
- DIV, 1000, clock cycles per digit slot; at least 2.
- BLANK_CYC, 1, cycles at the start of each slot with all anodes off; 0 <= BLANK_CYC < DIV.
- HEX_MODE, 0, 1 shows codes 10..15 as A,b,C,d,E,F; 0 shows them blank.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  one-cycle strobe that captures value and dp_in.
- value  in  4*DIGITS  packed nibbles; bits [3:0] are digit 0, the rightmost digit.
- dp_in  in  DIGITS  decimal point request per digit (1 = lit).
- lz_en  in  1  leading-zero suppression enable; sampled live.
- seg  out  7  {a,b,c,d,e,f,g}, active-low.
- dp_n  out  1  decimal point, active-low.
- an_n  out  DIGITS  digit enables, active-low, one-cold.
- frame_start  out  1  one-cycle pulse when digit 0's slot begins.

Behaviour:
- Reset (async, active-high):
  - seg=7'b1111111, dp_n=1, an_n all ones, frame_start=0.
  - Prescaler=0, digit index=0.
  - Shadow and display registers=0, pending=0.
- Prescaler and slot advance:
  - The prescaler counts 0..DIV-1 and wraps.
  - At a wrap, the digit index advances by 1, from DIGITS-1 back to 0.
- Load capture:
  - load=1 captures value and dp_in into the shadow register and sets pending.
- Frame-synchronous display update:
  - The display register updates only at the edge where the index wraps DIGITS-1 to 0, and only if pending=1 or load=1 on that edge.
  - On that edge it takes load ? value : shadow, and pending clears. This prevents tearing.
  - A load coincident with the wrap edge is therefore visible in the new frame.
  - Multiple loads within one frame: the last one wins.
- Output timing:
  - All outputs are registered and derived from the current index and prescaler state with one cycle of latency.
  - frame_start=1 for exactly one cycle: the first cycle an_n reflects slot 0. This includes the first cycle after reset release.
- Blanking gap:
  - While prescaler < BLANK_CYC, an_n is all ones.
  - Otherwise an_n[idx]=0 and all other bits are 1.
  - seg and dp_n are always valid for the current idx.
- Glyphs, seg = {a..g}, active-low:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100.
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
  - HEX_MODE=1: A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
  - HEX_MODE=0: codes 10..15 show 1111111.
- Decimal point: dp_n = ~dp bit of the current digit in the display register.
- Leading-zero suppression (lz_en=1):
  - Scanning from digit DIGITS-1 downward, each digit with nibble=0 and dp=0 is blanked (seg=1111111), until the first digit that fails that test.
  - Digit 0 is never suppressed.
  - A suppressed digit still has its anode driven.
- Reset mid-scan: returns immediately to the reset state; the latched value is lost.
- DIGITS=1: the index stays 0 and frame_start pulses every DIV cycles.

Test Plan (DIGITS=4, DIV=4, BLANK_CYC=1, HEX_MODE=0 unless stated):
- Reset release, no load:
  - Each slot is 4 cycles: 1 cycle an_n=1111, then 3 cycles one-cold.
  - Slots run 1110, 1101, 1011, 0111 and repeat.
  - seg=0000001 throughout; frame_start pulses every 16 cycles.
- load value=16'h1234 mid-frame:
  - The current frame still shows 0000.
  - From the next frame_start: digit0 seg=1001100 (4), digit1=0000110, digit2=0010010, digit3=1001111.
- lz_en=1, value=16'h0070, dp_in=0:
  - Digits 3 and 2 show 1111111 with anodes active.
  - digit1=0001111, digit0=0000001.
  - Same case with dp_in=4'b0100: digit2 shows 0000001 with dp_n=0.
- HEX_MODE=1, value=16'hABCF:
  - Per-digit seg: digit0=0111000, digit1=0110001, digit2=1100000, digit3=0001000.
  - Same value with HEX_MODE=0: all four digits show 1111111.
- Two loads in one frame (16'h1111, then 16'h9999), then a load of 16'h5555 on the wrap edge:
  - The next frame shows 9s on the first pair; 5s on the second case.
  - The value 1111 is never displayed.
- Assert rst during slot 2:
  - Same cycle: an_n=1111, seg=1111111, dp_n=1.
  - After release: scan restarts at digit 0 showing 0.
